// File: rtl/scope_capture_ctrl_pkg.sv
// Shared definitions for the oscilloscope capture path: state encoding and
// default frame geometry used by the capture, VGA timing and display blocks.
package scope_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TRIG = 2'd1,
        ST_CAPTURE   = 2'd2,
        ST_WAIT_SWAP = 2'd3
    } scope_state_e;

    localparam int SCOPE_SAMPLE_W     = 8;
    localparam int SCOPE_DEPTH        = 640;
    localparam int SCOPE_ADDR_W       = 10;
    localparam int SCOPE_AUTO_TIMEOUT = 4096;

endpackage

// File: rtl/scope_capture_ctrl_if.sv
// Frame-buffer write port plus the bank select the display side reads from.
interface scope_capture_ctrl_if
    import scope_pkg::*;
#(
    parameter int SAMPLE_W = SCOPE_SAMPLE_W,
    parameter int ADDR_W   = SCOPE_ADDR_W
);
    logic                wr_en;
    logic                wr_bank;
    logic [ADDR_W-1:0]   wr_addr;
    logic [SAMPLE_W-1:0] wr_data;
    logic                disp_bank;

    modport master (
        output wr_en,
        output wr_bank,
        output wr_addr,
        output wr_data,
        output disp_bank
    );

    modport slave (
        input wr_en,
        input wr_bank,
        input wr_addr,
        input wr_data,
        input disp_bank
    );
endinterface

// File: rtl/scope_capture_ctrl_trig_detect.sv
// Threshold-crossing detector: remembers the previous valid sample while
// tracking and flags a rising or falling crossing of the trigger level.
module trig_detect
    import scope_pkg::*;
#(
    parameter int SAMPLE_W = SCOPE_SAMPLE_W
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                track,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [SAMPLE_W-1:0] trig_level,
    input  logic                trig_rising,
    output logic                crossing
);

    logic [SAMPLE_W-1:0] prev_q, prev_d;
    logic                prev_valid_q, prev_valid_d;
    logic                rise_hit, fall_hit;

    // The history is dropped whenever we are not waiting for a trigger, so a
    // fresh arm always needs one sample of its own before it can fire.
    always_comb begin
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        if (!track) begin
            prev_valid_d = 1'b0;
        end else if (sample_valid) begin
            prev_d       = sample;
            prev_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
        end
    end

    assign rise_hit = (prev_q <  trig_level) && (sample >= trig_level);
    assign fall_hit = (prev_q >= trig_level) && (sample <  trig_level);
    assign crossing = sample_valid && prev_valid_q && (trig_rising ? rise_hit : fall_hit);

endmodule

// File: rtl/scope_capture_ctrl.sv
// Capture controller: waits for a trigger, streams one frame of samples into
// the back bank of a double-buffered frame store and swaps banks on vblank.
module scope_capture_ctrl
    import scope_pkg::*;
#(
    parameter int SAMPLE_W     = SCOPE_SAMPLE_W,
    parameter int DEPTH        = SCOPE_DEPTH,
    parameter int ADDR_W       = SCOPE_ADDR_W,
    parameter int AUTO_TIMEOUT = SCOPE_AUTO_TIMEOUT
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    sample_valid,
    input  logic [SAMPLE_W-1:0]     sample,
    input  logic [SAMPLE_W-1:0]     trig_level,
    input  logic                    trig_rising,
    input  logic                    auto_en,
    input  logic                    mode_single,
    input  logic                    arm,
    input  logic                    stop,
    input  logic                    vblank_start,
    scope_capture_ctrl_if.master    fb,
    output logic [1:0]              state,
    output logic                    frame_done
);

    localparam int                CNT_W     = $clog2(AUTO_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(AUTO_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    scope_state_e        state_q, state_d;
    logic                disp_bank_q, disp_bank_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [SAMPLE_W-1:0] wr_data_q, wr_data_d;
    logic                frame_done_q, frame_done_d;
    logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;

    logic                crossing;
    logic                force_trig;
    logic [ADDR_W-1:0]   addr_next;

    trig_detect #(
        .SAMPLE_W (SAMPLE_W)
    ) u_trig_detect (
        .clock        (clock),
        .reset_n      (reset_n),
        .track        (state_q == ST_WAIT_TRIG),
        .sample_valid (sample_valid),
        .sample       (sample),
        .trig_level   (trig_level),
        .trig_rising  (trig_rising),
        .crossing     (crossing)
    );

    assign force_trig = auto_en && (tmo_cnt_q == CNT_LAST);
    assign addr_next  = wr_addr_q + 1'b1;

    // stop is checked first so it wins over arm and abandons any partial frame
    // without touching the displayed bank; the timeout counter only lives in
    // WAIT_TRIG and saturates so a late auto_en still fires promptly.
    always_comb begin
        state_d      = state_q;
        disp_bank_d  = disp_bank_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        tmo_cnt_d    = (state_q == ST_WAIT_TRIG) ? tmo_cnt_q : '0;

        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm || !mode_single) state_d = ST_WAIT_TRIG;
                end
                ST_WAIT_TRIG: begin
                    if (sample_valid) begin
                        if (crossing || force_trig) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = '0;
                            wr_data_d = sample;
                            state_d   = (DEPTH == 1) ? ST_WAIT_SWAP : ST_CAPTURE;
                        end else if (tmo_cnt_q != CNT_LAST) begin
                            tmo_cnt_d = tmo_cnt_q + 1'b1;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (sample_valid) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_next;
                        wr_data_d = sample;
                        if (addr_next == ADDR_LAST) state_d = ST_WAIT_SWAP;
                    end
                end
                ST_WAIT_SWAP: begin
                    if (vblank_start) begin
                        disp_bank_d  = ~disp_bank_q;
                        frame_done_d = 1'b1;
                        state_d      = mode_single ? ST_IDLE : ST_WAIT_TRIG;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            disp_bank_q  <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            tmo_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            disp_bank_q  <= disp_bank_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    assign state        = state_q;
    assign frame_done   = frame_done_q;
    assign fb.wr_en     = wr_en_q;
    assign fb.wr_addr   = wr_addr_q;
    assign fb.wr_data   = wr_data_q;
    assign fb.disp_bank = disp_bank_q;
    assign fb.wr_bank   = ~disp_bank_q;

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Directed bench for scope_capture_ctrl: a frame-level reference model checked
// every cycle, plus literal expectations pinned on key cycles.
module tb_scope_capture_ctrl;

    localparam int SW           = 8;
    localparam int AW           = 10;
    localparam int DEPTH        = 640;
    localparam int AUTO_TIMEOUT = 16;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          sample_valid;
    logic [SW-1:0] sample;
    logic [SW-1:0] trig_level;
    logic          trig_rising;
    logic          auto_en;
    logic          mode_single;
    logic          arm;
    logic          stop;
    logic          vblank_start;
    logic [1:0]    state;
    logic          frame_done;

    scope_capture_ctrl_if #(.SAMPLE_W(SW), .ADDR_W(AW)) fb ();

    scope_capture_ctrl #(
        .SAMPLE_W     (SW),
        .DEPTH        (DEPTH),
        .ADDR_W       (AW),
        .AUTO_TIMEOUT (AUTO_TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .sample       (sample),
        .trig_level   (trig_level),
        .trig_rising  (trig_rising),
        .auto_en      (auto_en),
        .mode_single  (mode_single),
        .arm          (arm),
        .stop         (stop),
        .vblank_start (vblank_start),
        .fb           (fb),
        .state        (state),
        .frame_done   (frame_done)
    );

    always #5 clock = ~clock;

    // Reference model: mode 0 idle, 1 waiting, 2 capturing, 3 waiting for swap.
    int mState, mPrev, mCnt, mPos, expAddr, expData;
    bit mPrevValid, mDisp, expWrEn, expFd;

    int pinState, pinWrEn, pinAddr, pinData, pinDisp, pinWrBank, pinFd;
    int checks, errors;
    bit checkEn;

    task automatic modelReset();
        mState = 0; mPrev = 0; mCnt = 0; mPos = 0; mPrevValid = 0; mDisp = 0;
        expWrEn = 0; expAddr = 0; expData = 0; expFd = 0;
    endtask

    task automatic modelStep();
        int s;
        int lvl;
        bit trig;
        s = int'(sample);
        lvl = int'(trig_level);
        expWrEn = 0;
        expFd = 0;
        if (stop) begin
            mState = 0;
            return;
        end
        case (mState)
            0: if (arm || !mode_single) begin
                mState = 1; mPrevValid = 0; mCnt = 0;
            end
            1: if (sample_valid) begin
                trig = 0;
                if (mPrevValid)
                    trig = trig_rising ? (mPrev < lvl && s >= lvl) : (mPrev >= lvl && s < lvl);
                if (auto_en && mCnt == AUTO_TIMEOUT - 1) trig = 1;
                if (trig) begin
                    expWrEn = 1; expAddr = 0; expData = s; mPos = 1;
                    mState = (DEPTH == 1) ? 3 : 2;
                end else begin
                    mPrev = s; mPrevValid = 1;
                    if (mCnt < AUTO_TIMEOUT - 1) mCnt++;
                end
            end
            2: if (sample_valid) begin
                expWrEn = 1; expAddr = mPos; expData = s;
                if (mPos == DEPTH - 1) mState = 3;
                mPos++;
            end
            3: if (vblank_start) begin
                mDisp = !mDisp; expFd = 1;
                mState = mode_single ? 0 : 1;
                mPrevValid = 0; mCnt = 0;
            end
            default: ;
        endcase
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (checkEn) begin
            checkOutput("state", 32'(state), mState);
            checkOutput("wr_en", 32'(fb.wr_en), 32'(expWrEn));
            if (expWrEn) begin
                checkOutput("wr_addr", 32'(fb.wr_addr), expAddr);
                checkOutput("wr_data", 32'(fb.wr_data), expData);
            end
            checkOutput("disp_bank", 32'(fb.disp_bank), 32'(mDisp));
            checkOutput("wr_bank", 32'(fb.wr_bank), 32'(!mDisp));
            checkOutput("frame_done", 32'(frame_done), 32'(expFd));
            if (pinState  >= 0) checkOutput("pin_state", 32'(state), pinState);
            if (pinWrEn   >= 0) checkOutput("pin_wr_en", 32'(fb.wr_en), pinWrEn);
            if (pinAddr   >= 0) checkOutput("pin_wr_addr", 32'(fb.wr_addr), pinAddr);
            if (pinData   >= 0) checkOutput("pin_wr_data", 32'(fb.wr_data), pinData);
            if (pinDisp   >= 0) checkOutput("pin_disp_bank", 32'(fb.disp_bank), pinDisp);
            if (pinWrBank >= 0) checkOutput("pin_wr_bank", 32'(fb.wr_bank), pinWrBank);
            if (pinFd     >= 0) checkOutput("pin_frame_done", 32'(frame_done), pinFd);
        end
    end

    task automatic clearPins();
        pinState = -1; pinWrEn = -1; pinAddr = -1; pinData = -1;
        pinDisp = -1; pinWrBank = -1; pinFd = -1;
    endtask

    // One clock of stimulus; pins set by the caller are checked after this edge.
    task automatic applyStimulus(input bit sv, input int s, input bit a = 0,
                                 input bit st = 0, input bit vb = 0);
        sample_valid = sv;
        sample = 8'(s);
        arm = a;
        stop = st;
        vblank_start = vb;
        modelStep();
        @(negedge clock);
        #1;
        clearPins();
        sample_valid = 0; arm = 0; stop = 0; vblank_start = 0;
    endtask

    task automatic doReset();
        reset_n = 0;
        modelReset();
        sample_valid = 0; arm = 0; stop = 0; vblank_start = 0; sample = 0;
        @(negedge clock);
        #1;
        reset_n = 1;
        clearPins();
    endtask

    initial begin
        checks = 0; errors = 0; checkEn = 0;
        mode_single = 1; trig_rising = 1; trig_level = 128; auto_en = 0;
        clearPins();
        checkEn = 1;
        pinState = 0; pinWrEn = 0; pinDisp = 0; pinWrBank = 1; pinFd = 0;
        doReset();

        // Continuous rising trigger on a ramp, then stop mid-capture.
        mode_single = 0;
        pinState = 1; applyStimulus(0, 0);
        applyStimulus(1, 100);
        applyStimulus(1, 120);
        pinState = 2; pinWrEn = 1; pinAddr = 0; pinData = 140; applyStimulus(1, 140);
        for (int i = 1; i <= 300; i++) begin
            if (i == 300) begin pinAddr = 300; pinData = 52; end
            applyStimulus(1, (i * 7) % 256);
        end
        mode_single = 1;
        pinState = 0; pinWrEn = 0; pinDisp = 0; applyStimulus(1, 99, 0, 1);
        pinState = 0; pinWrEn = 0; applyStimulus(1, 200);

        // Falling trigger, full frame, swap on vblank.
        mode_single = 0; trig_rising = 0; trig_level = 50;
        pinState = 1; applyStimulus(0, 0);
        pinState = 1; pinWrEn = 0; applyStimulus(1, 60);
        pinState = 2; pinWrEn = 1; pinAddr = 0; pinData = 40; applyStimulus(1, 40);
        for (int i = 1; i <= 639; i++) begin
            if (i == 639) begin
                pinState = 3; pinAddr = 639; pinData = 125; pinWrBank = 1; pinDisp = 0;
            end
            applyStimulus(1, (i * 3) % 256);
        end
        pinState = 3; pinWrEn = 0; applyStimulus(1, 10);
        pinState = 1; pinDisp = 1; pinWrBank = 0; pinFd = 1; applyStimulus(0, 0, 0, 0, 1);
        pinFd = 0; pinDisp = 1; applyStimulus(0, 0);
        mode_single = 1;
        pinState = 0; applyStimulus(0, 0, 0, 1);

        // Reset during capture abandons the frame and restores bank 0.
        trig_rising = 1; trig_level = 128;
        pinState = 1; applyStimulus(0, 0, 1);
        applyStimulus(1, 0);
        pinState = 2; pinWrEn = 1; pinAddr = 0; pinData = 200; applyStimulus(1, 200);
        for (int i = 1; i <= 50; i++) applyStimulus(1, i);
        pinState = 0; pinWrEn = 0; pinDisp = 0; pinWrBank = 1; pinFd = 0;
        doReset();
        pinState = 0; applyStimulus(1, 200);
        mode_single = 0;
        pinState = 1; applyStimulus(0, 0);
        mode_single = 1;
        pinState = 0; applyStimulus(0, 0, 0, 1);
        pinState = 0; applyStimulus(0, 0, 1, 1);

        // Forced trigger on the 16th valid sample of a flat signal.
        auto_en = 1;
        pinState = 1; applyStimulus(0, 0, 1);
        for (int i = 1; i <= 16; i++) begin
            if (i == 8) applyStimulus(0, 0);
            if (i == 16) begin
                pinWrEn = 1; pinAddr = 0; pinData = 10; pinState = 2;
            end else begin
                pinWrEn = 0; pinState = 1;
            end
            applyStimulus(1, 10);
        end
        pinState = 0; applyStimulus(0, 0, 0, 1);
        auto_en = 0;

        // Single shot with vblank coincident with the last sample.
        pinState = 0; pinWrEn = 0; applyStimulus(1, 200);
        pinState = 1; applyStimulus(0, 0, 1);
        applyStimulus(1, 0);
        pinState = 2; pinWrEn = 1; pinAddr = 0; pinData = 200; applyStimulus(1, 200);
        for (int i = 1; i <= 639; i++) begin
            if (i == 639) begin
                pinState = 3; pinAddr = 639; pinData = 127; pinDisp = 0; pinFd = 0;
            end
            applyStimulus(1, i % 256, 0, 0, i == 639);
        end
        pinState = 3; pinDisp = 0; pinFd = 0; pinWrEn = 0; applyStimulus(1, 50);
        pinState = 0; pinDisp = 1; pinFd = 1; applyStimulus(0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            pinState = 0; pinWrEn = 0; pinFd = 0;
            applyStimulus(1, (k % 2 == 1) ? 200 : 0);
        end
        pinState = 1; pinDisp = 1; applyStimulus(0, 0, 1);
        applyStimulus(1, 0);
        pinState = 2; pinWrEn = 1; pinAddr = 0; pinData = 250; applyStimulus(1, 250);
        pinState = 0; pinWrEn = 0; applyStimulus(0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
